// File: rtl/uart_pkg.sv
// Shared types and constants for the UART echo block.
// Optional even-parity framing is enabled by defining UART_ECHO_PARITY_EN.
package uart_pkg;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

`ifdef UART_ECHO_PARITY_EN
    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_t;
`else
    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_STOP
    } tx_state_t;
`endif

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with registered read data (not first-word-fall-through)
// and a registered occupancy count.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic [WIDTH-1:0]               wr_data,
    input  logic                           pop,
    output logic [WIDTH-1:0]               rd_data,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the same edge frees a slot.
    assign do_push = push && (!full || do_pop);

    // NOTE: storage has no reset; only pointers and level define validity.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wr_data;
    end

    // NOTE: non-blocking assignments keep every register updating from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            rd_data <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/uart_echo_fifo.sv
// UART loopback: receiver -> FIFO -> transmitter, gated by echo_en.
// Define UART_ECHO_PARITY_EN for even-parity framing in both directions.
module uart_echo_fifo
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                rx,
    output logic                                tx,
    input  logic                                echo_en,
    output logic                                rx_strobe,
    output logic                                frame_err,
    output logic                                ovf_err,
    output logic                                err,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_level
);

    localparam int CPB = clks_per_bit(CLK_HZ, BAUD);
    localparam int CW  = $clog2(CPB);
    localparam int BW  = $clog2(DATA_BITS);

    localparam logic [CW-1:0] BIT_LAST  = CW'(CPB - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CPB / 2 - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);

    logic rx_meta, rx_sync, rx_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= IDLE_LEVEL;
            rx_sync <= IDLE_LEVEL;
            rx_prev <= IDLE_LEVEL;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    rx_state_t            rx_state;
    logic [CW-1:0]        rx_cnt;
    logic [BW-1:0]        rx_idx;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_bad;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_q;
    logic                 tx_pop;

`ifdef UART_ECHO_PARITY_EN
    logic rx_par;
    // Even parity: data bits plus parity bit must XOR to zero.
    assign rx_bad = (rx_sync == START_LEVEL) || (^{rx_data, rx_par});
`else
    assign rx_bad = (rx_sync == START_LEVEL);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state  <= RX_IDLE;
            rx_cnt    <= '0;
            rx_idx    <= '0;
            rx_data   <= '0;
            rx_strobe <= 1'b0;
            frame_err <= 1'b0;
            ovf_err   <= 1'b0;
            err       <= 1'b0;
`ifdef UART_ECHO_PARITY_EN
            rx_par    <= 1'b0;
`endif
        end else begin
            rx_strobe <= 1'b0;
            frame_err <= 1'b0;
            ovf_err   <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev == IDLE_LEVEL && rx_sync == START_LEVEL) begin
                        rx_cnt   <= HALF_LAST;
                        rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_cnt != '0)
                        rx_cnt <= rx_cnt - CW'(1);
                    else if (rx_sync != START_LEVEL)
                        rx_state <= RX_IDLE;
                    else begin
                        rx_cnt   <= BIT_LAST;
                        rx_idx   <= '0;
                        rx_state <= RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt != '0)
                        rx_cnt <= rx_cnt - CW'(1);
                    else begin
                        rx_data <= {rx_sync, rx_data[DATA_BITS-1:1]};
                        rx_cnt  <= BIT_LAST;
                        if (rx_idx == DATA_LAST)
`ifdef UART_ECHO_PARITY_EN
                            rx_state <= RX_PARITY;
`else
                            rx_state <= RX_STOP;
`endif
                        else
                            rx_idx <= rx_idx + BW'(1);
                    end
                end
`ifdef UART_ECHO_PARITY_EN
                RX_PARITY: begin
                    if (rx_cnt != '0)
                        rx_cnt <= rx_cnt - CW'(1);
                    else begin
                        rx_par   <= rx_sync;
                        rx_cnt   <= BIT_LAST;
                        rx_state <= RX_STOP;
                    end
                end
`endif
                RX_STOP: begin
                    if (rx_cnt != '0)
                        rx_cnt <= rx_cnt - CW'(1);
                    else begin
                        // Return at once so a start edge right after mid-stop is caught.
                        rx_state <= RX_IDLE;
                        if (rx_bad) begin
                            frame_err <= 1'b1;
                            err       <= 1'b1;
                        end else if (fifo_full) begin
                            ovf_err <= 1'b1;
                            err     <= 1'b1;
                        end else
                            rx_strobe <= 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (rx_strobe),
        .wr_data (rx_data),
        .pop     (tx_pop),
        .rd_data (fifo_q),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    tx_state_t            tx_state;
    logic [CW-1:0]        tx_cnt;
    logic [BW-1:0]        tx_idx;
    logic [DATA_BITS-1:0] tx_shift;
`ifdef UART_ECHO_PARITY_EN
    logic                 tx_par;
`endif

    // Popping at the end of STOP chains characters with no idle gap.
    assign tx_pop = echo_en && !fifo_empty &&
                    (tx_state == TX_IDLE || (tx_state == TX_STOP && tx_cnt == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx       <= IDLE_LEVEL;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shift <= '0;
`ifdef UART_ECHO_PARITY_EN
            tx_par   <= 1'b0;
`endif
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (tx_pop) begin
                        tx       <= START_LEVEL;
                        tx_cnt   <= BIT_LAST;
                        tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_cnt != '0)
                        tx_cnt <= tx_cnt - CW'(1);
                    else begin
                        // Registered FIFO data is stable by now, a full bit after the pop.
                        tx       <= fifo_q[0];
                        tx_shift <= fifo_q >> 1;
`ifdef UART_ECHO_PARITY_EN
                        tx_par   <= ^fifo_q;
`endif
                        tx_idx   <= '0;
                        tx_cnt   <= BIT_LAST;
                        tx_state <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt != '0)
                        tx_cnt <= tx_cnt - CW'(1);
                    else begin
                        tx_cnt <= BIT_LAST;
                        if (tx_idx == DATA_LAST) begin
`ifdef UART_ECHO_PARITY_EN
                            tx       <= tx_par;
                            tx_state <= TX_PARITY;
`else
                            tx       <= IDLE_LEVEL;
                            tx_state <= TX_STOP;
`endif
                        end else begin
                            tx       <= tx_shift[0];
                            tx_shift <= tx_shift >> 1;
                            tx_idx   <= tx_idx + BW'(1);
                        end
                    end
                end
`ifdef UART_ECHO_PARITY_EN
                TX_PARITY: begin
                    if (tx_cnt != '0)
                        tx_cnt <= tx_cnt - CW'(1);
                    else begin
                        tx       <= IDLE_LEVEL;
                        tx_cnt   <= BIT_LAST;
                        tx_state <= TX_STOP;
                    end
                end
`endif
                TX_STOP: begin
                    if (tx_cnt != '0)
                        tx_cnt <= tx_cnt - CW'(1);
                    else if (tx_pop) begin
                        tx       <= START_LEVEL;
                        tx_cnt   <= BIT_LAST;
                        tx_state <= TX_START;
                    end else
                        tx_state <= TX_IDLE;
                end
                default: begin
                    tx       <= IDLE_LEVEL;
                    tx_state <= TX_IDLE;
                end
            endcase
        end
    end

endmodule
